// File: rtl/keypad_pkg.sv
// Shared constants for the keypad event scanner: register map, field positions
// and the FIFO event record.
package keypad_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_PERIOD = 3'd1;
   localparam logic [2:0] ADDR_STATE  = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_EVENT  = 3'd4;

   localparam int CTRL_ENABLE     = 0;
   localparam int CTRL_IRQ_EN     = 1;
   localparam int CTRL_REPORT_REL = 2;
   localparam int CTRL_FLUSH      = 31;

   localparam int STATUS_OVF  = 16;
   localparam int EVENT_VALID = 31;
   localparam int EVENT_PRESS = 8;

   localparam int KEY_IDX_W = 8;
   localparam int EVENT_W   = KEY_IDX_W + 1;

   typedef struct packed {
      logic                 press;
      logic [KEY_IDX_W-1:0] key;
   } kp_event_t;

   // Shortest row dwell that still lets a full row of events drain before the next sample.
   function automatic logic [31:0] min_dwell(input int cols);
      return 32'(cols + 4);
   endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Synchronous event FIFO with flush; head is read combinationally so a pop
// and its data land in the same bus cycle.
module kp_event_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = EVENT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rdata   = mem[rd_ptr_reg];
   // A simultaneous pop frees the slot a push into a full FIFO needs.
   assign push_ok = push && (!full || pop) && !flush;
   assign pop_ok  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

endmodule

// File: rtl/keypad_event_scanner.sv
// Avalon-MM keypad scanner: row strobing, per-key frame debounce and a
// press/release event FIFO with a level interrupt.
module keypad_event_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int FIFO_DEPTH      = 8,
   parameter int PERIOD_RESET    = 1000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            avs_write,
   input  logic            avs_read,
   input  logic [2:0]      avs_address,
   input  logic [31:0]     avs_writedata,
   output logic [31:0]     avs_readdata,
   output logic            irq,
   output logic [ROWS-1:0] rows,
   input  logic [COLS-1:0] cols
);

   localparam int NKEYS = ROWS * COLS;
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DB_W  = 4;
   localparam logic [31:0] DWELL_MIN = min_dwell(COLS);

   logic            ctrl_enable_reg;
   logic            ctrl_irq_en_reg;
   logic            ctrl_rel_reg;
   logic [31:0]     period_reg;
   logic            overflow_reg;
   logic            irq_reg;
   logic [31:0]     readdata_reg;
   logic [COLS-1:0] col_meta_reg;
   logic [COLS-1:0] col_sync_reg;
   logic [ROW_W-1:0] row_reg;
   logic [31:0]     dwell_reg;
   logic [COLS-1:0] pend_mask_reg;
   logic [COLS-1:0] pend_press_reg;
   logic [ROW_W-1:0] pend_row_reg;

   logic [COLS-1:0] raw;
   logic [31:0]     dwell_last;
   logic            sample_now;
   logic [NKEYS-1:0] key_state;
   logic [NKEYS-1:0] key_flip;
   logic [COLS-1:0] row_flip;
   logic [COLS-1:0] drain_onehot;
   logic [COL_W-1:0] drain_col;
   logic [31:0]     state_word;
   logic [31:0]     rd_mux;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   kp_event_t        fifo_wdata;
   kp_event_t        fifo_rdata;

   assign raw        = ~col_sync_reg;
   assign dwell_last = ((period_reg < DWELL_MIN) ? DWELL_MIN : period_reg) - 32'd1;
   // >= keeps the scan alive if PERIOD is lowered while a long dwell is in progress.
   assign sample_now = ctrl_enable_reg && (dwell_reg >= dwell_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta_reg <= '1;
         col_sync_reg <= '1;
      end else begin
         col_meta_reg <= cols;
         col_sync_reg <= col_meta_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_reg   <= '0;
         dwell_reg <= '0;
      end else if (!ctrl_enable_reg) begin
         row_reg   <= '0;
         dwell_reg <= '0;
      end else if (sample_now) begin
         dwell_reg <= '0;
         row_reg   <= (row_reg == ROW_W'(ROWS - 1)) ? '0 : row_reg + 1'b1;
      end else begin
         dwell_reg <= dwell_reg + 32'd1;
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign rows[gi] = (ctrl_enable_reg && (row_reg == ROW_W'(gi))) ? 1'b0 : 1'bz;
   end

   for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      localparam int KR = gi / COLS;
      localparam int KC = gi % COLS;
      logic [DB_W-1:0] cnt_reg;
      logic            state_reg;
      logic            hit;
      logic            differs;

      assign hit           = sample_now && (row_reg == ROW_W'(KR));
      assign differs       = (raw[KC] != state_reg);
      assign key_flip[gi]  = hit && differs && (cnt_reg == DB_W'(DEBOUNCE_FRAMES - 1));
      assign key_state[gi] = state_reg;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_reg   <= '0;
            state_reg <= 1'b0;
         end else if (!ctrl_enable_reg) begin
            cnt_reg <= '0;
         end else if (hit) begin
            if (!differs || key_flip[gi]) cnt_reg <= '0;
            else                          cnt_reg <= cnt_reg + 1'b1;
            if (key_flip[gi]) state_reg <= ~state_reg;
         end
      end
   end

   // Only the sampled row can flip, so folding all rows onto columns is exact.
   always_comb begin
      row_flip = '0;
      for (int k = 0; k < NKEYS; k++) begin
         row_flip[k % COLS] = row_flip[k % COLS] | key_flip[k];
      end
   end

   assign drain_onehot = pend_mask_reg & (~pend_mask_reg + 1'b1);

   always_comb begin
      drain_col = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (pend_mask_reg[c]) drain_col = COL_W'(c);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_mask_reg  <= '0;
         pend_press_reg <= '0;
         pend_row_reg   <= '0;
      end else if (!ctrl_enable_reg) begin
         pend_mask_reg <= '0;
      end else if (sample_now) begin
         pend_mask_reg  <= row_flip;
         pend_press_reg <= raw;
         pend_row_reg   <= row_reg;
      end else begin
         pend_mask_reg <= pend_mask_reg & ~drain_onehot;
      end
   end

   assign fifo_wdata.press = |(drain_onehot & pend_press_reg);
   assign fifo_wdata.key   = KEY_IDX_W'(int'(pend_row_reg) * COLS + int'(drain_col));
   assign fifo_push  = ctrl_enable_reg && (|pend_mask_reg) && (fifo_wdata.press || ctrl_rel_reg);
   assign fifo_flush = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_FLUSH];
   assign fifo_pop   = avs_read && (avs_address == ADDR_EVENT) && !fifo_empty;

   kp_event_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(EVENT_W)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (fifo_push),
      .pop  (fifo_pop),
      .flush(fifo_flush),
      .wdata(fifo_wdata),
      .rdata(fifo_rdata),
      .count(fifo_count),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   if (NKEYS >= 32) begin : g_state_wide
      assign state_word = key_state[31:0];
   end else begin : g_state_narrow
      assign state_word = {{(32 - NKEYS){1'b0}}, key_state};
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_ENABLE]     = ctrl_enable_reg;
            rd_mux[CTRL_IRQ_EN]     = ctrl_irq_en_reg;
            rd_mux[CTRL_REPORT_REL] = ctrl_rel_reg;
         end
         ADDR_PERIOD: rd_mux = period_reg;
         ADDR_STATE:  rd_mux = state_word;
         ADDR_STATUS: begin
            rd_mux[7:0]        = 8'(fifo_count);
            rd_mux[STATUS_OVF] = overflow_reg;
         end
         ADDR_EVENT: begin
            if (!fifo_empty) begin
               rd_mux[EVENT_VALID] = 1'b1;
               rd_mux[EVENT_PRESS] = fifo_rdata.press;
               rd_mux[7:0]         = fifo_rdata.key;
            end
         end
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_enable_reg <= 1'b0;
         ctrl_irq_en_reg <= 1'b0;
         ctrl_rel_reg    <= 1'b0;
         period_reg      <= 32'(PERIOD_RESET);
         overflow_reg    <= 1'b0;
         irq_reg         <= 1'b0;
         readdata_reg    <= '0;
      end else begin
         if (avs_write && (avs_address == ADDR_CTRL)) begin
            ctrl_enable_reg <= avs_writedata[CTRL_ENABLE];
            ctrl_irq_en_reg <= avs_writedata[CTRL_IRQ_EN];
            ctrl_rel_reg    <= avs_writedata[CTRL_REPORT_REL];
         end
         if (avs_write && (avs_address == ADDR_PERIOD)) begin
            period_reg <= avs_writedata;
         end
         if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[STATUS_OVF]) begin
            overflow_reg <= 1'b0;
         end
         if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) begin
            overflow_reg <= 1'b1;
         end
         irq_reg <= ctrl_irq_en_reg && (!fifo_empty || overflow_reg);
         if (avs_read) begin
            readdata_reg <= rd_mux;
         end
      end
   end

   assign avs_readdata = readdata_reg;
   assign irq          = irq_reg;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench for keypad_event_scanner: a keypad matrix model on pulled-up
// rows/cols and a scoreboard of expected bus reads and FIFO events.
module tb_keypad_event_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        avs_write = 1'b0;
   logic        avs_read = 1'b0;
   logic [2:0]  avs_address = 3'd0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic        irq;
   tri1 [ROWS-1:0] rows_bus;
   logic [COLS-1:0] cols;
   logic [ROWS*COLS-1:0] keys = '0;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ev_q[$];

   always #5 clk = ~clk;

   keypad_event_scanner #(
      .ROWS(ROWS),
      .COLS(COLS),
      .DEBOUNCE_FRAMES(3),
      .FIFO_DEPTH(8),
      .PERIOD_RESET(1000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .avs_write    (avs_write),
      .avs_read     (avs_read),
      .avs_address  (avs_address),
      .avs_writedata(avs_writedata),
      .avs_readdata (avs_readdata),
      .irq          (irq),
      .rows         (rows_bus),
      .cols         (cols)
   );

   // A closed key shorts its column to a row that is being driven low.
   always_comb begin
      cols = '1;
      for (int r = 0; r < ROWS; r++) begin
         if (rows_bus[r] === 1'b0) begin
            for (int c = 0; c < COLS; c++) begin
               if (keys[r*COLS + c]) cols[c] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-12s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      avs_write = 1'b1; avs_address = a; avs_writedata = d;
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      avs_read = 1'b1; avs_address = a;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      exp_q.push_back(exp);
      bus_read(a, d);
      check(tag, d, exp_q.pop_front());
   endtask

   task automatic rd_event(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      e = (ev_q.size() > 0) ? ev_q.pop_front() : 32'd0;
      bus_read(3'd4, d);
      check(tag, d, e);
   endtask

   // Returns at the first cycle of row r's dwell.
   task automatic wait_row(input int r);
      int n;
      n = 0;
      while (rows_bus[r] === 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
      while (rows_bus[r] !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      assert (n < 300) else begin
         errors++;
         $error("FAIL wait_row%0d observed=timeout expected=row low", r);
      end
   endtask

   initial begin
      int n;
      int press_list[10];
      press_list = '{0, 2, 4, 5, 7, 9, 10, 11, 12, 13};

      // Reset state
      cycles(3);
      check("rst_rows", 32'(rows_bus), 32'h0000000F);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", avs_readdata, 32'd0);
      reset = 1'b0;
      rd_check(3'd0, 32'd0, "rst_ctrl");
      rd_check(3'd1, 32'd1000, "rst_period");
      rd_check(3'd2, 32'd0, "rst_state");
      rd_check(3'd3, 32'd0, "rst_status");
      rd_event("rst_event");
      rd_check(3'd5, 32'd0, "unused_addr");

      // Single press with a clamped dwell
      bus_write(3'd1, 32'd3);
      rd_check(3'd1, 32'd3, "period_wr");
      bus_write(3'd0, 32'h3);
      wait_row(1);
      n = 0;
      while (rows_bus[1] === 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
      check("dwell_len", 32'(n), 32'd8);
      keys[6] = 1'b1;
      ev_q.push_back(32'h80000106);
      cycles(128);
      rd_check(3'd2, 32'h00000040, "state_k6");
      check("irq_pend", 32'(irq), 32'd1);
      rd_event("ev_k6");
      check("irq_hold", 32'(irq), 32'd1);
      cycles(1);
      check("irq_fall", 32'(irq), 32'd0);
      rd_event("ev_empty");
      keys[6] = 1'b0;
      cycles(128);
      rd_check(3'd2, 32'd0, "state_rel6");
      rd_check(3'd3, 32'd0, "no_rel_ev");

      // Two-frame pulse is rejected
      wait_row(2);
      keys[8] = 1'b1;
      cycles(48);
      keys[8] = 1'b0;
      cycles(96);
      rd_check(3'd2, 32'd0, "pulse_state");
      rd_check(3'd3, 32'd0, "pulse_status");
      check("pulse_irq", 32'(irq), 32'd0);

      // Two keys in the same row, same frame
      keys[1] = 1'b1;
      keys[3] = 1'b1;
      ev_q.push_back(32'h80000101);
      ev_q.push_back(32'h80000103);
      cycles(128);
      rd_check(3'd2, 32'h0000000A, "state_k1k3");
      rd_event("ev_k1");
      rd_event("ev_k3");
      keys[1] = 1'b0;
      keys[3] = 1'b0;
      cycles(128);
      rd_check(3'd2, 32'd0, "state_rel13");

      // Release reporting
      bus_write(3'd0, 32'h7);
      keys[15] = 1'b1;
      ev_q.push_back(32'h8000010F);
      cycles(128);
      keys[15] = 1'b0;
      ev_q.push_back(32'h8000000F);
      cycles(128);
      rd_event("ev_p15");
      rd_event("ev_r15");
      rd_check(3'd3, 32'd0, "status_5");

      // Overflow, flush and overflow clear
      bus_write(3'd0, 32'h3);
      wait_row(0);
      for (int i = 0; i < 10; i++) begin
         keys[press_list[i]] = 1'b1;
         if (i < 8) ev_q.push_back(32'h80000100 | 32'(press_list[i]));
      end
      cycles(192);
      rd_check(3'd3, 32'h00010008, "ovf_status");
      check("ovf_irq", 32'(irq), 32'd1);
      rd_event("ovf_first");
      rd_check(3'd3, 32'h00010007, "ovf_pop");
      bus_write(3'd0, 32'h80000003);
      bus_write(3'd3, 32'h00010000);
      ev_q.delete();
      rd_check(3'd3, 32'd0, "flush_status");
      check("flush_irq", 32'(irq), 32'd0);
      rd_event("flush_event");

      // Disable stops row drive; reset mid-operation
      bus_write(3'd0, 32'h2);
      check("dis_rows", 32'(rows_bus), 32'h0000000F);
      reset = 1'b1;
      cycles(1);
      check("mid_rdata", avs_readdata, 32'd0);
      reset = 1'b0;
      rd_check(3'd1, 32'd1000, "mid_period");
      rd_check(3'd2, 32'd0, "mid_state");
      rd_check(3'd0, 32'd0, "mid_ctrl");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
